cpu_pio_led_pulse: RTL and testbench

Memory-mapped output PIO for the Nios system, the output-side counterpart of the key-input PIO. It drives board LEDs/strobes from a CPU-written data register with atomic set/clear, and adds a hardware one-shot pulse engine that holds selected bits high for a programmed cycle count, then raises a completion interrupt. It sits on the system interconnect as an Avalon-MM slave with a 1-cycle registered read.

---
 rtl/cpu_pio_led_pulse_pkg.sv | 29 ++
 rtl/cpu_pio_led_pulse_if.sv | 29 ++
 rtl/cpu_pio_led_pulse_timer.sv | 80 ++++++++
 rtl/cpu_pio_led_pulse.sv | 126 ++++++++++++
 tb/tb_cpu_pio_led_pulse.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pio_led_pulse_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pio_pkg
// Shared definitions for the LED/strobe output PIO with one-shot pulse engine:
// register word offsets, EVENT register bit positions and the pulse FSM state.
// -----------------------------------------------------------------------------
package cpu_pio_pkg;

  localparam int ADDR_W = 3;
  localparam int BUS_W  = 32;

  // Register word offsets
  localparam logic [ADDR_W-1:0] REG_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] REG_PLEN     = 3'd1;
  localparam logic [ADDR_W-1:0] REG_IRQ_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] REG_EVENT    = 3'd3;
  localparam logic [ADDR_W-1:0] REG_OUTSET   = 3'd4;
  localparam logic [ADDR_W-1:0] REG_OUTCLR   = 3'd5;
  localparam logic [ADDR_W-1:0] REG_PULSE    = 3'd6;

  // EVENT register bit positions
  localparam int EVT_DONE    = 0;
  localparam int EVT_OVERRUN = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/cpu_pio_led_pulse_if.sv
// -----------------------------------------------------------------------------
// cpu_pio_led_pulse_if
// Avalon-MM slave bus of the output PIO, plus its level interrupt.
//   address     word offset          chipselect  slave select
//   write_n     active-low write     writedata   write data (upper bits unused)
//   readdata    registered read data irq         level interrupt
// master: CPU / interconnect side.  slave: PIO side.
// -----------------------------------------------------------------------------
interface cpu_pio_led_pulse_if;
  import cpu_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/cpu_pio_led_pulse_timer.sv
// -----------------------------------------------------------------------------
// pio_pulse_timer
// One-shot pulse engine: on an accepted start it holds a bit mask for exactly
// i_len cycles, then reports completion.
//   clk, reset_n          clock, async active-low reset
//   i_start               PULSE register write this cycle
//   i_mask, i_len         requested bit mask and length in cycles
//   o_pulse_mask_nxt      pulse mask as it will be after this edge
//   o_busy                a pulse is running
//   o_done_pulse          pulse finishes at this edge (1-cycle strobe)
//   o_overrun_pulse       start arrived while busy and was dropped
// -----------------------------------------------------------------------------
module pio_pulse_timer
  import cpu_pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [LEN_W-1:0] i_len,
  output logic [WIDTH-1:0] o_pulse_mask_nxt,
  output logic             o_busy,
  output logic             o_done_pulse,
  output logic             o_overrun_pulse
);

  pulse_state_t     r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mask;
  logic             w_launch;
  logic             w_finish;

  // A zero mask or zero length is a no-op command, not an event.
  assign w_launch = i_start && (r_state == IDLE) && (i_mask != '0) && (i_len != '0);
  // The counter stops at 1, so the maximum length never wraps.
  assign w_finish = (r_state == ACTIVE) && (r_cnt == LEN_W'(1));

  assign o_busy          = (r_state == ACTIVE);
  assign o_done_pulse    = w_finish;
  assign o_overrun_pulse = i_start && (r_state == ACTIVE);

  // The top registers its output pins from this next-state value so the
  // pins change on the same edge as the mask register.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    o_pulse_mask_nxt = r_mask;
    if (w_launch)      o_pulse_mask_nxt = i_mask;
    else if (w_finish) o_pulse_mask_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else begin
      r_mask <= o_pulse_mask_nxt;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state <= ACTIVE;
            r_cnt   <= i_len;
          end
        end
        ACTIVE: begin
          r_cnt <= r_cnt - LEN_W'(1);
          if (w_finish) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_pio_led_pulse.sv
// -----------------------------------------------------------------------------
// cpu_pio_led_pulse
// Memory-mapped output PIO with atomic set/clear and a one-shot pulse engine.
//   clk, reset_n   clock, async active-low reset
//   bus            Avalon-MM slave (address/chipselect/write_n/writedata in,
//                  readdata/irq out); 1-cycle registered read
//   out_port       registered output pins = data | pulse mask
// Map: 0 DATA, 1 PLEN, 2 IRQ_MASK, 3 EVENT {overrun,done} (write clears),
//      4 OUTSET, 5 OUTCLR, 6 PULSE (write starts, read busy), 7 unused.
// -----------------------------------------------------------------------------
module cpu_pio_led_pulse
  import cpu_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               LEN_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  cpu_pio_led_pulse_if.slave  bus,
  output logic [WIDTH-1:0]    out_port
);

  logic [WIDTH-1:0] r_data;
  logic [LEN_W-1:0] r_plen;
  logic             r_irq_mask;
  logic             r_done;
  logic             r_overrun;
  logic [BUS_W-1:0] r_readdata;
  logic             r_irq;
  logic [WIDTH-1:0] r_out_port;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_irq_mask_nxt;
  logic             w_done_nxt;
  logic             w_overrun_nxt;
  logic             w_evt_clr;
  logic             w_start;
  logic [WIDTH-1:0] w_pulse_mask_nxt;
  logic             w_busy;
  logic             w_done_pulse;
  logic             w_overrun_pulse;
  logic [BUS_W-1:0] w_rd_mux;
  logic             w_unused_wd;

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_wd      = bus.writedata[WIDTH-1:0];
  assign w_evt_clr = w_wr && (bus.address == REG_EVENT);
  assign w_start   = w_wr && (bus.address == REG_PULSE);
  // Write-data bits above the register widths are ignored.
  assign w_unused_wd = ^bus.writedata;

  pio_pulse_timer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_timer (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_start          (w_start),
    .i_mask           (w_wd),
    .i_len            (r_plen),
    .o_pulse_mask_nxt (w_pulse_mask_nxt),
    .o_busy           (w_busy),
    .o_done_pulse     (w_done_pulse),
    .o_overrun_pulse  (w_overrun_pulse)
  );

  always_comb begin
    w_data_nxt = r_data;
    if (w_wr) begin
      case (bus.address)
        REG_DATA:   w_data_nxt = w_wd;
        REG_OUTSET: w_data_nxt = r_data | w_wd;
        REG_OUTCLR: w_data_nxt = r_data & ~w_wd;
        default:    w_data_nxt = r_data;
      endcase
    end
  end

  assign w_irq_mask_nxt = (w_wr && (bus.address == REG_IRQ_MASK)) ? bus.writedata[0] : r_irq_mask;
  // Set beats clear: a completion coinciding with an EVENT write is kept.
  assign w_done_nxt     = w_done_pulse    | (r_done    & ~w_evt_clr);
  assign w_overrun_nxt  = w_overrun_pulse | (r_overrun & ~w_evt_clr);

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      REG_DATA:     w_rd_mux[WIDTH-1:0] = r_data;
      REG_PLEN:     w_rd_mux[LEN_W-1:0] = r_plen;
      REG_IRQ_MASK: w_rd_mux[0]         = r_irq_mask;
      REG_EVENT: begin
        w_rd_mux[EVT_DONE]    = r_done;
        w_rd_mux[EVT_OVERRUN] = r_overrun;
      end
      REG_PULSE:    w_rd_mux[0]         = w_busy;
      default:      w_rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE;
      r_plen     <= '0;
      r_irq_mask <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
      r_out_port <= RESET_VALUE;
    end else begin
      r_data     <= w_data_nxt;
      if (w_wr && (bus.address == REG_PLEN)) r_plen <= bus.writedata[LEN_W-1:0];
      r_irq_mask <= w_irq_mask_nxt;
      r_done     <= w_done_nxt;
      r_overrun  <= w_overrun_nxt;
      // Loaded every cycle regardless of chipselect.
      r_readdata <= w_rd_mux;
      r_irq      <= w_done_nxt & w_irq_mask_nxt;
      r_out_port <= w_data_nxt | w_pulse_mask_nxt;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_irq;
  assign out_port     = r_out_port;

endmodule

// File: tb/tb_cpu_pio_led_pulse.sv
// -----------------------------------------------------------------------------
// tb_cpu_pio_led_pulse
// Self-checking bench for cpu_pio_led_pulse (WIDTH=8, RESET_VALUE=A5, LEN_W=16).
// Expected pin values and read data are pushed to queues when stimulus is
// driven and popped when the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_cpu_pio_led_pulse;
  import cpu_pio_pkg::*;

  localparam int         WIDTH = 8;
  localparam int         LEN_W = 16;
  localparam logic [7:0] RV    = 8'hA5;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b1;
  logic [WIDTH-1:0] out_port;

  cpu_pio_led_pulse_if bus();

  cpu_pio_led_pulse #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV),
    .LEN_W       (LEN_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  q_out[$];
  logic [31:0] q_rd[$];
  logic [7:0]  exp_out;
  logic [31:0] exp_rd;
  logic [7:0]  m_data;

  // Drive one write cycle; returns just after the sampling edge.
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  // Present a read address; readdata is valid just after the returning edge.
  task automatic bus_rd(input logic [2:0] a);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #12;
    q_out.push_back(RV);
    q_rd.push_back(32'h0);
    exp_out = q_out.pop_front();
    n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL reset_out: got %h want %h", out_port, exp_out); end
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL reset_rd: got %h want %h", bus.readdata, exp_rd); end
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    @(negedge clk) reset_n = 1'b1;
    m_data = RV;
    q_rd.push_back(32'h0);
    bus_rd(REG_PULSE);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL reset_busy: got %h want %h", bus.readdata, exp_rd); end
    q_rd.push_back({24'h0, m_data});
    bus_rd(REG_DATA);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL reset_data_rd: got %h want %h", bus.readdata, exp_rd); end
  endtask

  task automatic test_data_ops();
    logic [2:0]  ops_a [3] = '{REG_DATA, REG_OUTSET, REG_OUTCLR};
    logic [31:0] ops_d [3] = '{32'h0000_000F, 32'hABCD_0030, 32'h0000_0003};
    for (int i = 0; i < 3; i++) begin
      case (ops_a[i])
        REG_DATA:   m_data = ops_d[i][7:0];
        REG_OUTSET: m_data = m_data | ops_d[i][7:0];
        default:    m_data = m_data & ~ops_d[i][7:0];
      endcase
      q_out.push_back(m_data);
      bus_wr(ops_a[i], ops_d[i]);
      exp_out = q_out.pop_front();
      n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL data_op%0d: got %h want %h", i, out_port, exp_out); end
    end
    q_rd.push_back(32'h0000_003C);
    bus_rd(REG_DATA);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL data_rd: got %h want %h", bus.readdata, exp_rd); end
  endtask

  task automatic test_pulse();
    bus_wr(REG_PLEN, 32'd5);
    bus_wr(REG_IRQ_MASK, 32'd1);
    m_data = 8'h00;
    bus_wr(REG_DATA, 32'h0);
    for (int j = 0; j <= 5; j++) q_out.push_back(j < 5 ? (m_data | 8'h81) : m_data);
    bus_wr(REG_PULSE, 32'h81);
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      exp_out = q_out.pop_front();
      n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL pulse_out c%0d: got %h want %h", j, out_port, exp_out); end
      n_cmp++; if (bus.irq !== (j == 5)) begin n_err++; $display("FAIL pulse_irq c%0d: got %b want %b", j, bus.irq, (j == 5)); end
    end
    q_rd.push_back(32'h1);
    bus_rd(REG_EVENT);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL pulse_event: got %h want %h", bus.readdata, exp_rd); end
    bus_wr(REG_EVENT, 32'h0);
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL pulse_irq_clr: got %b want 0", bus.irq); end
  endtask

  task automatic test_overrun();
    bus_wr(REG_PLEN, 32'd10);
    for (int j = 0; j <= 10; j++) q_out.push_back(j < 10 ? (m_data | 8'h10) : m_data);
    bus_wr(REG_PULSE, 32'h10);
    for (int j = 0; j <= 10; j++) begin
      if (j == 1) bus_wr(REG_PULSE, 32'h02);
      else if (j == 2) begin q_rd.push_back(32'h1); bus_rd(REG_PULSE); end
      else if (j == 3) begin q_rd.push_back(32'h2); bus_rd(REG_EVENT); end
      else if (j > 3) begin @(posedge clk); #1; end
      exp_out = q_out.pop_front();
      n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL ovr_out c%0d: got %h want %h", j, out_port, exp_out); end
      n_cmp++; if (bus.irq !== (j == 10)) begin n_err++; $display("FAIL ovr_irq c%0d: got %b want %b", j, bus.irq, (j == 10)); end
      if (j == 2 || j == 3) begin
        exp_rd = q_rd.pop_front();
        n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL ovr_rd c%0d: got %h want %h", j, bus.readdata, exp_rd); end
      end
    end
    q_rd.push_back(32'h3);
    bus_rd(REG_EVENT);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL ovr_event_end: got %h want %h", bus.readdata, exp_rd); end
    bus_wr(REG_EVENT, 32'h0);
  endtask

  task automatic test_boundary();
    // One-cycle pulse.
    bus_wr(REG_PLEN, 32'd1);
    q_out.push_back(m_data | 8'h04);
    q_out.push_back(m_data);
    bus_wr(REG_PULSE, 32'h04);
    exp_out = q_out.pop_front();
    n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL len1_on: got %h want %h", out_port, exp_out); end
    @(posedge clk); #1;
    exp_out = q_out.pop_front();
    n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL len1_off: got %h want %h", out_port, exp_out); end
    n_cmp++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL len1_irq: got %b want 1", bus.irq); end
    bus_wr(REG_EVENT, 32'h0);
    // EVENT clear on the completion edge: the new done survives.
    bus_wr(REG_PLEN, 32'd2);
    bus_wr(REG_PULSE, 32'h08);
    bus_wr(REG_IRQ_MASK, 32'd1);
    q_out.push_back(m_data);
    bus_wr(REG_EVENT, 32'h0);
    exp_out = q_out.pop_front();
    n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL race_out: got %h want %h", out_port, exp_out); end
    n_cmp++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL race_irq: got %b want 1", bus.irq); end
    q_rd.push_back(32'h1);
    bus_rd(REG_EVENT);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL race_event: got %h want %h", bus.readdata, exp_rd); end
    bus_wr(REG_EVENT, 32'h0);
  endtask

  task automatic test_ignored();
    bus_wr(REG_PLEN, 32'd0);
    bus_wr(REG_PULSE, 32'hFF);
    q_rd.push_back(32'h0);
    bus_rd(REG_PULSE);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL ign_busy: got %h want %h", bus.readdata, exp_rd); end
    bus_wr(REG_PLEN, 32'd4);
    bus_wr(REG_PULSE, 32'h00);
    for (int j = 0; j < 5; j++) begin
      q_out.push_back(m_data);
      @(posedge clk); #1;
      exp_out = q_out.pop_front();
      n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL ign_out c%0d: got %h want %h", j, out_port, exp_out); end
    end
    q_rd.push_back(32'h0);
    bus_rd(REG_EVENT);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL ign_event: got %h want %h", bus.readdata, exp_rd); end
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL ign_irq: got %b want 0", bus.irq); end
  endtask

  task automatic test_reset_mid();
    bus_wr(REG_PLEN, 32'd8);
    bus_wr(REG_PULSE, 32'hF0);
    n_cmp++; if (out_port !== (m_data | 8'hF0)) begin n_err++; $display("FAIL mid_on: got %h want %h", out_port, m_data | 8'hF0); end
    repeat (2) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    q_out.push_back(RV);
    exp_out = q_out.pop_front();
    n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL mid_async_out: got %h want %h", out_port, exp_out); end
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL mid_async_irq: got %b want 0", bus.irq); end
    @(negedge clk) reset_n = 1'b1;
    m_data = RV;
    q_rd.push_back(32'h0);
    bus_rd(REG_EVENT);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL mid_event: got %h want %h", bus.readdata, exp_rd); end
    q_rd.push_back(32'h0);
    bus_rd(REG_PULSE);
    exp_rd = q_rd.pop_front();
    n_cmp++; if (bus.readdata !== exp_rd) begin n_err++; $display("FAIL mid_busy: got %h want %h", bus.readdata, exp_rd); end
    repeat (8) begin @(posedge clk); #1; end
    q_out.push_back(m_data);
    exp_out = q_out.pop_front();
    n_cmp++; if (out_port !== exp_out) begin n_err++; $display("FAIL mid_after_out: got %h want %h", out_port, exp_out); end
    n_cmp++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL mid_after_irq: got %b want 0", bus.irq); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    test_reset();
    test_data_ops();
    test_pulse();
    test_overrun();
    test_boundary();
    test_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
